// File: rtl/poly_pitch_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : poly_pitch_generator_pkg
// Purpose  : Register map constants and sizing helper for the polyphonic
//            pitch generator.
// Revision : 1.0 - initial release
// ============================================================================
package poly_pitch_generator_pkg;

  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_DUR    = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/poly_pitch_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : poly_pitch_generator_if
// Purpose  : MIO register bus between the CPU side and the pitch generator.
// Revision : 1.0 - initial release
// ============================================================================
interface poly_pitch_generator_if #(
  parameter int AW = 4
) ();
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/poly_pitch_generator_tone_channel.sv
`default_nettype none
// ============================================================================
// Module   : tone_channel
// Purpose  : One square-wave voice: half-period counter, wave toggle and
//            optional millisecond duration that silences the voice.
// Revision : 1.0 - initial release
// ============================================================================
module tone_channel #(
  parameter int DIV_W = 20,
  parameter int DUR_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             period_we,
  input  wire logic             dur_we,
  input  wire logic             tick,
  input  wire logic [DIV_W-1:0] period_data,
  input  wire logic [DUR_W-1:0] dur_data,
  output logic                  wave,
  output logic                  active,
  output logic                  expire,
  output logic [DIV_W-1:0]      period,
  output logic [DUR_W-1:0]      remaining
);

  logic [DIV_W-1:0] phase;
  logic             chan_we;

  // Any CPU write to this voice takes priority over a tick in the same cycle.
  assign chan_we = period_we | dur_we;
  assign expire  = tick && active && (remaining == DUR_W'(1)) && !chan_we;

  // Period/phase/wave state; a write restarts the phase, expiry silences.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period <= '0;
      phase  <= '0;
      wave   <= 1'b0;
      active <= 1'b0;
    end else if (period_we) begin
      period <= period_data;
      phase  <= '0;
      wave   <= 1'b0;
      active <= |period_data;
    end else if (expire) begin
      period <= '0;
      phase  <= '0;
      wave   <= 1'b0;
      active <= 1'b0;
    end else if (active) begin
      if (phase == period - DIV_W'(1)) begin
        phase <= '0;
        wave  <= ~wave;
      end else begin
        phase <= phase + DIV_W'(1);
      end
    end
  end

  // Remaining duration: loaded by the CPU, counts down on ms ticks while playing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else if (dur_we) begin
      remaining <= dur_data;
    end else if (!period_we && tick && active && (remaining != '0)) begin
      remaining <= remaining - DUR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/poly_pitch_generator.sv
`default_nettype none
// ============================================================================
// Module   : poly_pitch_generator
// Purpose  : N_CH tone voices mixed onto a 1-bit buzzer line through a
//            first-order sigma-delta modulator, with ms prescaler and
//            sticky note-done interrupt flags.
// Revision : 1.0 - initial release
// ============================================================================
module poly_pitch_generator
  import poly_pitch_generator_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DIV_W    = 20,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 100000
) (
  input  wire logic              clk,
  input  wire logic              rst,
  poly_pitch_generator_if.slave  bus,
  output logic                   irq,
  output logic                   buzzer
);

  localparam int CH_W  = (clog2(N_CH) < 1) ? 1 : clog2(N_CH);
  localparam int AW    = CH_W + 2;
  localparam int PRE_W = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
  localparam int SUM_W = clog2(N_CH + 1);
  localparam int ACC_W = clog2(2 * N_CH) + 1;

  logic [CH_W-1:0]  ch_sel;
  logic [1:0]       reg_sel;
  logic             ch_valid;
  logic [N_CH-1:0]  period_we;
  logic [N_CH-1:0]  dur_we;
  logic [N_CH-1:0]  w1c;
  logic [N_CH-1:0]  wave;
  logic [N_CH-1:0]  active;
  logic [N_CH-1:0]  expire;
  logic [N_CH-1:0]  done;
  logic [DIV_W-1:0] period    [N_CH];
  logic [DUR_W-1:0] remaining [N_CH];
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_n;
  logic [31:0]      rdata;
  logic             unused_wdata;

  assign ch_sel       = bus.addr[AW-1:2];
  assign reg_sel      = bus.addr[1:0];
  assign tick         = (pre == PRE_W'(TICK_DIV - 1));
  assign irq          = |done;
  assign bus.rdata    = rdata;
  assign unused_wdata = ^bus.wdata;

  // Address decode into per-voice write strobes and CTRL clear mask.
  always_comb begin
    ch_valid  = 1'b0;
    period_we = '0;
    dur_we    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        ch_valid     = 1'b1;
        period_we[i] = bus.we && (reg_sel == REG_PERIOD);
        dur_we[i]    = bus.we && (reg_sel == REG_DUR);
      end
    end
    w1c = (bus.we && ch_valid && (reg_sel == REG_CTRL)) ? bus.wdata[N_CH-1:0] : '0;
  end

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      tone_channel #(.DIV_W(DIV_W), .DUR_W(DUR_W)) u_ch (
        .clk         (clk),
        .rst         (rst),
        .period_we   (period_we[g]),
        .dur_we      (dur_we[g]),
        .tick        (tick),
        .period_data (bus.wdata[DIV_W-1:0]),
        .dur_data    (bus.wdata[DUR_W-1:0]),
        .wave        (wave[g]),
        .active      (active[g]),
        .expire      (expire[g]),
        .period      (period[g]),
        .remaining   (remaining[g])
      );
    end
  endgenerate

  // Free-running ms prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + PRE_W'(1);
  end

  // Sticky done flags; a new expiry beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= '0;
    else     done <= (done & ~w1c) | expire;
  end

  // Combinational register read-back; unmapped slots read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        case (reg_sel)
          REG_PERIOD: rdata = 32'(period[i]);
          REG_DUR:    rdata = 32'(remaining[i]);
          REG_CTRL:   rdata = {16'(done), 16'(active)};
          default:    rdata = '0;
        endcase
      end
    end
  end

  // Count of voices currently high, fed to the modulator.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_CH; i++) sum = sum + SUM_W'(wave[i]);
    acc_n = acc + ACC_W'(sum);
  end

  // First-order sigma-delta: emit a 1 whenever the accumulator crosses N_CH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      buzzer <= 1'b0;
    end else if (acc_n >= ACC_W'(N_CH)) begin
      acc    <= acc_n - ACC_W'(N_CH);
      buzzer <= 1'b1;
    end else begin
      acc    <= acc_n;
      buzzer <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_poly_pitch_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_pitch_generator
// Purpose  : Directed self-checking bench for poly_pitch_generator
//            (N_CH=4, TICK_DIV=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_pitch_generator;
  import poly_pitch_generator_pkg::*;

  localparam int N_CH     = 4;
  localparam int DIV_W    = 20;
  localparam int DUR_W    = 16;
  localparam int TICK_DIV = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  logic buzzer;

  poly_pitch_generator_if #(.AW(4)) bus ();

  poly_pitch_generator #(
    .N_CH(N_CH), .DIV_W(DIV_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .irq    (irq),
    .buzzer (buzzer)
  );

  always #5 clk = ~clk;

  // Edges since reset release; its value mod TICK_DIV is the prescaler phase.
  int ncyc;
  always @(posedge clk or posedge rst) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] ad(input int ch, input logic [1:0] r);
    logic [31:0] c;
    c = 32'(ch);
    return {c[1:0], r};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    step(1);
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic align_pre(input int phase);
    for (int i = 0; i < TICK_DIV && (ncyc % TICK_DIV) != phase; i++) step(1);
  endtask

  logic [31:0] d;
  logic [39:0] v40;
  logic [11:0] v12;
  logic [6:0]  v7;
  int          ones;

  initial begin
    bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    rd(ad(0, REG_CTRL), d);
    chk("reset_ctrl", d, 0);
    chk("reset_irq", irq, 0);
    ones = 0;
    for (int k = 0; k < 20; k++) begin step(1); ones += buzzer; end
    chk("reset_idle_buzzer", ones, 0);

    // Single voice: ch0 half-period 5, toggles at +5, +10, ...
    wr(ad(0, REG_PERIOD), 5);
    rd(ad(0, REG_CTRL), d);
    chk("single_ctrl", d, 32'h0000_0001);
    rd(ad(0, REG_PERIOD), d);
    chk("single_period_rb", d, 5);
    rd(ad(0, 2'd3), d);
    chk("reserved_reads_zero", d, 0);
    for (int k = 0; k < 40; k++) begin step(1); v40[k] = buzzer; end
    chk("single_buzzer_pattern", v40, 40'h88_0402_0100);

    // Full chord: staggered loads, then rewrites 6 cycles apart to align phases
    wr(ad(0, REG_PERIOD), 3);
    wr(ad(1, REG_PERIOD), 3);
    wr(ad(2, REG_PERIOD), 3);
    wr(ad(3, REG_PERIOD), 3);
    step(2);
    wr(ad(0, REG_PERIOD), 3);
    step(5);
    wr(ad(1, REG_PERIOD), 3);
    step(5);
    wr(ad(2, REG_PERIOD), 3);
    step(5);
    wr(ad(3, REG_PERIOD), 3);
    for (int k = 0; k < 12; k++) begin step(1); v12[k] = buzzer; end
    chk("chord_pattern", v12, 12'hE38);
    rd(ad(2, REG_CTRL), d);
    chk("chord_ctrl", d, 32'h0000_000F);

    // Stop ch0 while all voices are high: density falls to 3/4
    step(3);
    wr(ad(0, REG_PERIOD), 0);
    rd(ad(0, REG_CTRL), d);
    chk("stop_ctrl", d, 32'h0000_000E);
    for (int k = 0; k < 7; k++) begin step(1); v7[k] = buzzer; end
    chk("stop_low_window", v7 & 7'h1C, 0);
    chk("stop_high_count", $countones(v7), 3);
    wr(ad(1, REG_PERIOD), 0);
    wr(ad(2, REG_PERIOD), 0);
    wr(ad(3, REG_PERIOD), 0);
    rd(ad(0, REG_CTRL), d);
    chk("all_stopped_ctrl", d, 0);

    // Timed note: ch1 period 4, duration 2 ticks
    align_pre(0);
    wr(ad(1, REG_PERIOD), 4);
    wr(ad(1, REG_DUR), 2);
    step(8);
    rd(ad(1, REG_DUR), d);
    chk("timed_after_tick1", d, 1);
    step(9);
    rd(ad(1, REG_CTRL), d);
    chk("timed_before_expiry_ctrl", d, 32'h0000_0002);
    chk("timed_before_expiry_irq", irq, 0);
    step(1);
    rd(ad(1, REG_CTRL), d);
    chk("timed_expired_ctrl", d, 32'h0002_0000);
    chk("timed_expired_irq", irq, 1);
    rd(ad(1, REG_PERIOD), d);
    chk("timed_period_cleared", d, 0);
    wr(ad(0, REG_CTRL), 32'h2);
    chk("w1c_irq", irq, 0);
    rd(ad(1, REG_CTRL), d);
    chk("w1c_ctrl", d, 0);
    ones = 0;
    for (int k = 0; k < 10; k++) begin step(1); ones += buzzer; end
    chk("silent_buzzer", ones, 0);

    // Collision: duration rewrite lands on the expiring tick
    align_pre(0);
    wr(ad(2, REG_PERIOD), 4);
    wr(ad(2, REG_DUR), 1);
    step(7);
    wr(ad(2, REG_DUR), 5);
    rd(ad(2, REG_DUR), d);
    chk("collision_remaining", d, 5);
    rd(ad(2, REG_CTRL), d);
    chk("collision_ctrl", d, 32'h0000_0004);
    chk("collision_irq", irq, 0);
    step(10);
    rd(ad(2, REG_DUR), d);
    chk("collision_next_tick", d, 4);
    rd(ad(2, REG_CTRL), d);
    chk("collision_still_playing", d, 32'h0000_0004);

    // Reset asserted mid-tone with a done flag pending
    wr(ad(3, REG_PERIOD), 1);
    wr(ad(3, REG_DUR), 1);
    step(12);
    chk("pre_reset_irq", irq, 1);
    bus.addr = ad(0, REG_CTRL);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_buzzer", buzzer, 0);
    chk("async_reset_irq", irq, 0);
    chk("async_reset_ctrl", bus.rdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ones = 0;
    for (int k = 0; k < 20; k++) begin step(1); ones += buzzer; end
    chk("post_reset_buzzer", ones, 0);
    rd(ad(2, REG_PERIOD), d);
    chk("post_reset_period", d, 0);
    chk("post_reset_irq", irq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
